// File: rtl/vc_switch_alloc_if.sv
// Port bundle between the 2-VC input buffer / credit return path and the switch allocator.
// master drives flits and credits; slave is the allocator.
interface vc_switch_alloc_if #(
    parameter int FLIT_W = 8
);
    logic [FLIT_W-1:0] vc0_flit;
    logic              vc0_valid;
    logic              vc0_ready;
    logic [FLIT_W-1:0] vc1_flit;
    logic              vc1_valid;
    logic              vc1_ready;
    logic              credit_in0;
    logic              credit_in1;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              out_vc;
    logic              err_drop;

    modport master (
        output vc0_flit, vc0_valid, vc1_flit, vc1_valid, credit_in0, credit_in1,
        input  vc0_ready, vc1_ready, out_flit, out_valid, out_vc, err_drop
    );

    modport slave (
        input  vc0_flit, vc0_valid, vc1_flit, vc1_valid, credit_in0, credit_in1,
        output vc0_ready, vc1_ready, out_flit, out_valid, out_vc, err_drop
    );
endinterface

// File: rtl/vc_switch_alloc.sv
// Two per-VC flit FIFOs arbitrated round-robin, packet-locked head to tail, onto one
// registered output link; forwarding is gated by per-VC downstream credit counters.
module vc_switch_alloc #(
    parameter int FLIT_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input logic          clk,
    input logic          rst,
    vc_switch_alloc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [1:0]    T_HEAD   = 2'b01;
    localparam logic [1:0]    T_TAIL   = 2'b10;
    localparam logic [1:0]    T_HT     = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [FLIT_W-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]     rd_q [2];
    logic [AW-1:0]     wr_q [2];
    logic [AW:0]       cnt_q [2];
    logic [CW-1:0]     cred_q [2];
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [FLIT_W-1:0] out_flit_q;
    logic              out_valid_q, out_vc_q, err_drop_q;

    logic [FLIT_W-1:0] flit_in [2];
    logic [FLIT_W-1:0] front [2];
    logic [1:0]        ftype [2];
    logic [1:0]        valid_in, credit_in, full, nempty, has_cred, push, pop, dec, cand;
    logic              sel, fwd, drop;

    // Decrement for a forwarded flit, then add a returned credit unless already at the cap.
    function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] c, input logic d,
                                                input logic inc);
        logic [CW-1:0] t;
        t = c - CW'(d);
        if (inc && t != CRED_MAX) t = t + CW'(1);
        return t;
    endfunction

    assign flit_in   = '{bus.vc0_flit, bus.vc1_flit};
    assign valid_in  = {bus.vc1_valid, bus.vc0_valid};
    assign credit_in = {bus.credit_in1, bus.credit_in0};

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            full[v]     = (cnt_q[v] == FULL_CNT);
            nempty[v]   = (cnt_q[v] != '0);
            has_cred[v] = (cred_q[v] != '0);
            front[v]    = mem_q[v][rd_q[v]];
            ftype[v]    = front[v][FLIT_W-1 -: 2];
            push[v]     = valid_in[v] & ~full[v];
        end
    end

    assign bus.vc0_ready = ~full[0];
    assign bus.vc1_ready = ~full[1];

    // Arbitration: IDLE picks a candidate (a flit that cannot open a packet is discarded
    // without needing credits); LOCKED serves only the owner until its TAIL leaves.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        sel     = 1'b0;
        fwd     = 1'b0;
        drop    = 1'b0;
        cand    = 2'b00;
        case (state_q)
            IDLE: begin
                for (int v = 0; v < 2; v++)
                    cand[v] = nempty[v] & (has_cred[v] | ~ftype[v][0]);
                if (cand != 2'b00) begin
                    sel = (cand == 2'b11) ? rr_q : cand[1];
                    if (ftype[sel] == T_HEAD) begin
                        fwd     = 1'b1;
                        state_d = LOCKED;
                        owner_d = sel;
                    end else if (ftype[sel] == T_HT) begin
                        fwd  = 1'b1;
                        rr_d = ~sel;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            LOCKED: begin
                sel = owner_q;
                if (nempty[sel]) begin
                    if (ftype[sel][0]) begin
                        drop = 1'b1;
                    end else if (has_cred[sel]) begin
                        fwd = 1'b1;
                        if (ftype[sel] == T_TAIL) begin
                            state_d = IDLE;
                            rr_d    = ~sel;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            pop[v] = (fwd | drop) & (sel == v[0]);
            dec[v] = fwd & (sel == v[0]);
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < 2; v++)
            if (push[v]) mem_q[v][wr_q[v]] <= flit_in[v];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                rd_q[v]   <= '0;
                wr_q[v]   <= '0;
                cnt_q[v]  <= '0;
                cred_q[v] <= CRED_MAX;
            end
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            out_vc_q    <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (push[v]) wr_q[v] <= wr_q[v] + AW'(1);
                if (pop[v])  rd_q[v] <= rd_q[v] + AW'(1);
                cnt_q[v]  <= cnt_q[v] + (AW + 1)'(push[v]) - (AW + 1)'(pop[v]);
                cred_q[v] <= cred_next(cred_q[v], dec[v], credit_in[v]);
            end
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            out_valid_q <= fwd;
            err_drop_q  <= drop;
            if (fwd) begin
                out_flit_q <= front[sel];
                out_vc_q   <= sel;
            end
        end
    end

    assign bus.out_flit  = out_flit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vc    = out_vc_q;
    assign bus.err_drop  = err_drop_q;
endmodule

// File: tb/tb_vc_switch_alloc.sv
// Bench for vc_switch_alloc: directed vector table, multi-cycle corner sequences and a
// randomized run against a queue-based packet/credit model.
module tb_vc_switch_alloc;
    localparam int FW      = 8;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_switch_alloc_if #(.FLIT_W(FW)) bus ();

    vc_switch_alloc #(.FLIT_W(FW), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: flit queues, credit counts and packet lock state.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         cr[2];
    bit         locked;
    int         owner;
    int         rr;
    bit         exp_valid, exp_vc, exp_drop;
    logic [7:0] exp_flit;

    typedef struct {
        bit v0; logic [7:0] f0; bit v1; logic [7:0] f1; bit c0; bit c1;
        bit ev; logic [7:0] ef; bit evc; bit ed;
    } vec_t;
    vec_t tbl[11];

    int         nfwd;
    logic [7:0] last_flit;
    logic [7:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit starts_pkt(input logic [7:0] f);
        return f[6];
    endfunction

    function automatic bit ends_pkt(input logic [7:0] f);
        return f[7];
    endfunction

    function automatic logic [7:0] qfront(input int v);
        return (v == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        cr[0] = CREDITS; cr[1] = CREDITS;
        locked = 1'b0; owner = 0; rr = 0;
        exp_valid = 1'b0; exp_vc = 1'b0; exp_drop = 1'b0; exp_flit = 8'h00;
    endtask

    task automatic model_edge(input bit v0, input logic [7:0] f0, input bit v1,
                              input logic [7:0] f1, input bit c0, input bit c1);
        int sz[2];
        bit acc[2];
        bit cnd[2];
        bit cin[2];
        int g;
        bit fwd, drp;
        logic [7:0] fr;
        sz[0] = q0.size(); sz[1] = q1.size();
        acc[0] = v0 && sz[0] < DEPTH;
        acc[1] = v1 && sz[1] < DEPTH;
        cin[0] = c0; cin[1] = c1;
        g = -1; fwd = 1'b0; drp = 1'b0; fr = 8'h00;
        if (!locked) begin
            for (int v = 0; v < 2; v++)
                cnd[v] = sz[v] > 0 && (cr[v] > 0 || !starts_pkt(qfront(v)));
            if (cnd[0] && cnd[1]) g = rr;
            else if (cnd[0]) g = 0;
            else if (cnd[1]) g = 1;
            if (g >= 0) begin
                fr = qfront(g);
                if (!starts_pkt(fr)) drp = 1'b1;
                else begin
                    fwd = 1'b1;
                    if (ends_pkt(fr)) rr = 1 - g;
                    else begin locked = 1'b1; owner = g; end
                end
            end
        end else if (sz[owner] > 0) begin
            g  = owner;
            fr = qfront(g);
            if (starts_pkt(fr)) drp = 1'b1;
            else if (cr[g] > 0) begin
                fwd = 1'b1;
                if (ends_pkt(fr)) begin locked = 1'b0; rr = 1 - g; end
            end
        end
        exp_valid = fwd;
        exp_drop  = drp;
        if (fwd) begin
            exp_flit = fr;
            exp_vc   = (g == 1);
            cr[g]--;
        end
        if (fwd || drp) begin
            if (g == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
        for (int v = 0; v < 2; v++)
            if (cin[v] && cr[v] < CREDITS) cr[v]++;
        if (acc[0]) q0.push_back(f0);
        if (acc[1]) q1.push_back(f1);
    endtask

    task automatic drive(input bit v0, input logic [7:0] f0, input bit v1, input logic [7:0] f1,
                         input bit c0, input bit c1);
        bus.vc0_valid  = v0;
        bus.vc0_flit   = f0;
        bus.vc1_valid  = v1;
        bus.vc1_flit   = f1;
        bus.credit_in0 = c0;
        bus.credit_in1 = c1;
    endtask

    // One clock: model follows the DUT edge; optionally compare every output to the model.
    task automatic tick(input bit cmp);
        bit v0, v1, c0, c1;
        logic [7:0] f0, f1;
        v0 = bus.vc0_valid; f0 = bus.vc0_flit; v1 = bus.vc1_valid; f1 = bus.vc1_flit;
        c0 = bus.credit_in0; c1 = bus.credit_in1;
        if (cmp) begin
            chk("vc0_ready", 32'(bus.vc0_ready), 32'(q0.size() < DEPTH));
            chk("vc1_ready", 32'(bus.vc1_ready), 32'(q1.size() < DEPTH));
        end
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(v0, f0, v1, f1, c0, c1);
        #1;
        if (bus.out_valid) begin
            nfwd++;
            last_flit = bus.out_flit;
            got.push_back(bus.out_flit);
        end
        if (cmp) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("out_flit",  32'(bus.out_flit),  32'(exp_flit));
            chk("out_vc",    32'(bus.out_vc),    32'(exp_vc));
            chk("err_drop",  32'(bus.err_drop),  32'(exp_drop));
        end
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rnd_flit();
        int r;
        logic [1:0] t;
        r = $urandom_range(0, 9);
        t = (r < 3) ? 2'b11 : (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : 2'b10;
        return {t, 6'($urandom)};
    endfunction

    task automatic reset_state_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_flit"},  32'(bus.out_flit),  32'd0);
        chk({tag, "_out_vc"},    32'(bus.out_vc),    32'd0);
        chk({tag, "_err_drop"},  32'(bus.err_drop),  32'd0);
        chk({tag, "_vc0_ready"}, 32'(bus.vc0_ready), 32'd1);
        chk({tag, "_vc1_ready"}, 32'(bus.vc1_ready), 32'd1);
    endtask

    initial begin
        nfwd = 0; last_flit = 8'h00;
        model_reset();
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_state_checks("reset");
        rst = 1'b0;

        // Directed vectors from reset: {v0,f0,v1,f1,c0,c1, out_valid,out_flit,out_vc,err_drop}
        tbl[0]  = '{1, 8'hC5, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0};
        tbl[1]  = '{0, 8'h00, 0, 8'h00, 0, 0,  1, 8'hC5, 0, 0};
        tbl[2]  = '{1, 8'h41, 1, 8'hD2, 0, 0,  0, 8'hC5, 0, 0};
        tbl[3]  = '{1, 8'h02, 0, 8'h00, 0, 0,  1, 8'hD2, 1, 0};
        tbl[4]  = '{1, 8'h83, 0, 8'h00, 0, 0,  1, 8'h41, 0, 0};
        tbl[5]  = '{0, 8'h00, 1, 8'h55, 0, 0,  1, 8'h02, 0, 0};
        tbl[6]  = '{0, 8'h00, 0, 8'h00, 0, 0,  1, 8'h83, 0, 0};
        tbl[7]  = '{0, 8'h00, 1, 8'hA0, 1, 0,  1, 8'h55, 1, 0};
        tbl[8]  = '{1, 8'h11, 0, 8'h00, 0, 0,  1, 8'hA0, 1, 0};
        tbl[9]  = '{0, 8'h00, 0, 8'h00, 0, 0,  0, 8'hA0, 1, 1};
        tbl[10] = '{0, 8'h00, 0, 8'h00, 0, 0,  0, 8'hA0, 1, 0};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v0, tbl[i].f0, tbl[i].v1, tbl[i].f1, tbl[i].c0, tbl[i].c1);
            tick(0);
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_out_flit", i),  32'(bus.out_flit),  32'(tbl[i].ef));
            chk($sformatf("vec%0d_out_vc", i),    32'(bus.out_vc),    32'(tbl[i].evc));
            chk($sformatf("vec%0d_err_drop", i),  32'(bus.err_drop),  32'(tbl[i].ed));
        end

        // Credit exhaustion: only CREDITS flits leave until credits return.
        do_reset();
        nfwd = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'hC0 + 8'(i), 0, 8'h00, 0, 0);
            tick(0);
        end
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        repeat (6) tick(0);
        chk("cred_exhaust_count", 32'(nfwd), 32'd4);
        nfwd = 0;
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        tick(0);
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        repeat (3) tick(0);
        chk("cred_return_count", 32'(nfwd), 32'd1);
        chk("cred_return_flit", 32'(last_flit), 32'hC4);

        // Credit saturation: extra returns beyond CREDITS are ignored.
        nfwd = 0;
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        repeat (5) tick(0);
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        repeat (4) tick(0);
        chk("cred_sat_drain_count", 32'(nfwd), 32'd1);
        nfwd = 0;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'hD0 + 8'(i), 0, 8'h00, 0, 0);
            tick(0);
        end
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        repeat (8) tick(0);
        chk("cred_sat_count", 32'(nfwd), 32'd4);
        chk("cred_sat_last_flit", 32'(last_flit), 32'hD3);

        // FIFO full: ready drops and a write while full is refused.
        for (int i = 6; i < 8; i++) begin
            drive(1, 8'hD0 + 8'(i), 0, 8'h00, 0, 0);
            tick(0);
        end
        chk("full_ready", 32'(bus.vc0_ready), 32'd0);
        drive(1, 8'hEE, 0, 8'h00, 0, 0);
        tick(0);
        chk("full_ready_hold", 32'(bus.vc0_ready), 32'd0);
        nfwd = 0;
        got.delete();
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        repeat (4) tick(0);
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        repeat (6) tick(0);
        chk("full_drain_count", 32'(nfwd), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("full_drain_flit%0d", i), 32'((i < got.size()) ? got[i] : 8'h00),
                32'(8'hD4 + 8'(i)));

        // Lock holds the other VC off; reset mid-packet clears buffers and lock.
        do_reset();
        drive(1, 8'h41, 1, 8'hC9, 0, 0);
        tick(0);
        drive(1, 8'h02, 0, 8'h00, 0, 0);
        tick(0);
        chk("lock_head_flit", 32'(bus.out_flit), 32'h41);
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        tick(0);
        chk("lock_body_flit", 32'(bus.out_flit), 32'h02);
        chk("lock_body_vc", 32'(bus.out_vc), 32'd0);
        tick(0);
        chk("lock_other_waits", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        #1;
        reset_state_checks("midpkt_reset");
        tick(0);
        rst = 1'b0;
        nfwd = 0;
        repeat (3) tick(0);
        chk("midpkt_flush_count", 32'(nfwd), 32'd0);
        drive(0, 8'h00, 1, 8'hC9, 0, 0);
        tick(0);
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        tick(0);
        chk("after_reset_valid", 32'(bus.out_valid), 32'd1);
        chk("after_reset_vc", 32'(bus.out_vc), 32'd1);
        chk("after_reset_flit", 32'(bus.out_flit), 32'hC9);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6, rnd_flit(), $urandom_range(0, 9) < 6, rnd_flit(),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
